// File: rtl/prewish_pattern_sequencer_pkg.sv
// Shared definitions for the blinky pattern sequencer: mask width and FSM state encoding.
// Combinational only; no latency.
// No flow control.
package prewish_pattern_sequencer_pkg;

    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/prewish_pattern_sequencer_ram.sv
// Pattern table: 2**ADDR_BITS x MASK_W, synchronous write, registered read, no reset.
// Read latency 1 cycle; a same-address write returns the old data.
// No backpressure; accepts one write and one read every cycle.
module prewish_pattern_sequencer_ram
    import prewish_pattern_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = 3
) (
    input  logic                 CLK_I,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [MASK_W-1:0]    wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [MASK_W-1:0]    rd_data
);

    logic [MASK_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge CLK_I) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/prewish_pattern_sequencer.sv
// Plays a table of LED masks into prewish_blinky, one strobe per entry, each held for a dwell.
// Strobes spaced max(dwell,1)+1 cycles; first strobe the cycle after start is accepted.
// No backpressure: the blinky load port always accepts; start while busy is ignored.
module prewish_pattern_sequencer
    import prewish_pattern_sequencer_pkg::*;
#(
    parameter int ADDR_BITS  = 3,
    parameter int DWELL_BITS = 24
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  i_wr_en,
    input  logic [ADDR_BITS-1:0]  i_wr_addr,
    input  logic [MASK_W-1:0]     i_wr_data,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [ADDR_BITS:0]    i_len,
    input  logic [DWELL_BITS-1:0] i_dwell,
    input  logic                  i_loop,
    output logic                  STB_O,
    output logic [MASK_W-1:0]     DAT_O,
    output logic                  o_busy,
    output logic [ADDR_BITS-1:0]  o_index,
    output logic                  o_done
);

    localparam logic [ADDR_BITS:0]    LEN_ONE = 1;
    localparam logic [ADDR_BITS-1:0]  IDX_ONE = 1;
    localparam logic [DWELL_BITS-1:0] DW_ONE  = 1;

    state_t                state;
    logic [ADDR_BITS:0]    len_q;
    logic [DWELL_BITS-1:0] dwell_q;
    logic                  loop_q;
    logic [DWELL_BITS-1:0] cnt;
    logic                  show_q;

    logic [ADDR_BITS-1:0]  rd_addr;
    logic [MASK_W-1:0]     rd_data;
    logic                  last_entry;
    logic                  cnt_done;
    logic [ADDR_BITS-1:0]  next_index;
    logic [DWELL_BITS-1:0] dwell_init;

    // len may equal the full depth, so the last-entry compare needs one extra bit
    assign last_entry = ({1'b0, o_index} + LEN_ONE) == len_q;
    assign next_index = last_entry ? '0 : o_index + IDX_ONE;
    assign cnt_done   = (cnt == '0);
    assign dwell_init = (dwell_q == '0) ? '0 : dwell_q - DW_ONE;

    // Address the entry that the next LOAD will show, so the RAM latency lands on the LOAD cycle
    always_comb begin
        rd_addr = o_index;
        if (state == S_IDLE) begin
            rd_addr = '0;
        end else if (state == S_DWELL && cnt_done) begin
            rd_addr = next_index;
        end
    end

    prewish_pattern_sequencer_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .CLK_I   (CLK_I),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign DAT_O = show_q ? rd_data : '0;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= S_IDLE;
            len_q   <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            cnt     <= '0;
            o_index <= '0;
            STB_O   <= 1'b0;
            show_q  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            STB_O  <= 1'b0;
            show_q <= 1'b0;
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop && i_len != '0) begin
                        len_q   <= i_len;
                        dwell_q <= i_dwell;
                        loop_q  <= i_loop;
                        o_index <= '0;
                        state   <= S_LOAD;
                        STB_O   <= 1'b1;
                        show_q  <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    cnt <= dwell_init;
                    if (i_stop) begin
                        state  <= S_CLEAR;
                        STB_O  <= 1'b1;
                        o_done <= 1'b1;
                    end else begin
                        state <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (i_stop || (cnt_done && last_entry && !loop_q)) begin
                        state  <= S_CLEAR;
                        STB_O  <= 1'b1;
                        o_done <= 1'b1;
                    end else if (cnt_done) begin
                        o_index <= next_index;
                        state   <= S_LOAD;
                        STB_O   <= 1'b1;
                        show_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - DW_ONE;
                    end
                end
                S_CLEAR: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prewish_pattern_sequencer.sv
// Bench for prewish_pattern_sequencer: directed scenarios plus randomized traffic against
// an event-time reference model (strobe k lands k*(max(dwell,1)+1) cycles after start).
module tb_prewish_pattern_sequencer;

    logic        CLK_I;
    logic        RST_I;
    logic        i_wr_en;
    logic [2:0]  i_wr_addr;
    logic [7:0]  i_wr_data;
    logic        i_start;
    logic        i_stop;
    logic [3:0]  i_len;
    logic [23:0] i_dwell;
    logic        i_loop;
    logic        STB_O;
    logic [7:0]  DAT_O;
    logic        o_busy;
    logic [2:0]  o_index;
    logic        o_done;

    prewish_pattern_sequencer #(.ADDR_BITS(3), .DWELL_BITS(24)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_len     (i_len),
        .i_dwell   (i_dwell),
        .i_loop    (i_loop),
        .STB_O     (STB_O),
        .DAT_O     (DAT_O),
        .o_busy    (o_busy),
        .o_index   (o_index),
        .o_done    (o_done)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 playing, 2 clear strobe showing
    int         cyc = 0;
    int         mode = 0;
    int         t0, m_len, m_p;
    bit         m_loop;
    logic [7:0] mtab [8];
    logic       e_stb = 0, e_busy = 0, e_done = 0;
    logic [7:0] e_dat = 0;
    logic [2:0] e_idx = 0;

    logic [7:0] log_dat [$];
    int         log_cyc [$];
    logic       log_done [$];
    logic [2:0] log_idx [$];

    task automatic model_step();
        int k, ph;
        e_stb  = 0;
        e_dat  = 0;
        e_done = 0;
        if (RST_I) begin
            mode   = 0;
            e_busy = 0;
            e_idx  = 0;
            return;
        end
        case (mode)
            0: if (i_start && !i_stop && i_len != 0) begin
                t0     = cyc;
                m_len  = int'(i_len);
                m_p    = ((i_dwell == 0) ? 1 : int'(i_dwell)) + 1;
                m_loop = i_loop;
                mode   = 1;
                e_stb  = 1;
                e_dat  = mtab[0];
                e_idx  = 0;
                e_busy = 1;
            end
            1: begin
                k  = (cyc - t0) / m_p;
                ph = (cyc - t0) % m_p;
                if (i_stop || (ph == 0 && !m_loop && k == m_len)) begin
                    mode   = 2;
                    e_stb  = 1;
                    e_done = 1;
                end else if (ph == 0) begin
                    e_stb = 1;
                    e_idx = 3'(k % m_len);
                    e_dat = mtab[k % m_len];
                end
            end
            default: begin
                mode   = 0;
                e_busy = 0;
            end
        endcase
        if (i_wr_en) mtab[i_wr_addr] = i_wr_data;
    endtask

    task automatic step();
        @(posedge CLK_I);
        cyc++;
        model_step();
        #1;
        chk("cycle", {18'd0, STB_O, DAT_O, o_busy, o_done, o_index},
                     {18'd0, e_stb, e_dat, e_busy, e_done, e_idx});
        if (STB_O) begin
            log_dat.push_back(DAT_O);
            log_cyc.push_back(cyc);
            log_done.push_back(o_done);
            log_idx.push_back(o_index);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_log();
        log_dat.delete();
        log_cyc.delete();
        log_done.delete();
        log_idx.delete();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        i_wr_en = 1; i_wr_addr = a; i_wr_data = d;
        step();
        i_wr_en = 0;
    endtask

    task automatic start(input logic [3:0] len, input logic [23:0] dw, input logic lp);
        i_start = 1; i_len = len; i_dwell = dw; i_loop = lp;
        step();
        i_start = 0;
    endtask

    task automatic stop_pulse();
        i_stop = 1;
        step();
        i_stop = 0;
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_n"}, log_dat.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk({tag, "_dat"}, {24'd0, log_dat[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        logic [7:0] s [$];
        RST_I = 1; i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0;
        i_start = 0; i_stop = 0; i_len = 0; i_dwell = 0; i_loop = 0;
        #1;
        chk("reset", {18'd0, STB_O, DAT_O, o_busy, o_done, o_index}, 32'd0);
        run(2);
        RST_I = 0;
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h00);
        wr(0, 8'hA5); wr(1, 8'h0F); wr(2, 8'hF0);

        // single pass, dwell 4
        clr_log();
        start(3, 4, 0);
        run(20);
        s = '{8'hA5, 8'h0F, 8'hF0, 8'h00};
        chk_seq("t1", s);
        for (int i = 0; i < 3; i++) chk("t1_gap", log_cyc[i+1] - log_cyc[i], 5);
        chk("t1_done", {31'd0, log_done[3]}, 1);
        chk("t1_busy", {31'd0, o_busy}, 0);

        // looping, stop during DWELL of the second-pass 0F
        clr_log();
        start(3, 4, 1);
        run(22);
        stop_pulse();
        run(3);
        s = '{8'hA5, 8'h0F, 8'hF0, 8'hA5, 8'h0F, 8'h00};
        chk_seq("t2", s);
        chk("t2_done", {31'd0, log_done[5]}, 1);
        chk("t2_busy", {31'd0, o_busy}, 0);

        // len=0 ignored; dwell=0 behaves as 1
        clr_log();
        start(0, 4, 0);
        run(5);
        chk("t3_len0_n", log_dat.size(), 0);
        chk("t3_len0_busy", {31'd0, o_busy}, 0);
        start(2, 0, 0);
        run(6);
        s = '{8'hA5, 8'h0F, 8'h00};
        chk_seq("t3_dw0", s);
        chk("t3_gap0", log_cyc[1] - log_cyc[0], 2);
        chk("t3_gap1", log_cyc[2] - log_cyc[1], 2);

        // rewrite entry 1 while it is showing
        clr_log();
        start(3, 4, 1);
        run(6);
        wr(1, 8'h3C);
        run(14);
        stop_pulse();
        run(3);
        s = '{8'hA5, 8'h0F, 8'hF0, 8'hA5, 8'h3C, 8'h00};
        chk_seq("t4", s);

        // async reset mid-DWELL
        start(3, 4, 1);
        run(7);
        #3 RST_I = 1;
        #1;
        chk("t5_rst_async", {18'd0, STB_O, DAT_O, o_busy, o_done, o_index}, 32'd0);
        run(2);
        RST_I = 0;
        clr_log();
        start(3, 4, 0);
        run(2);
        chk("t5_first", {24'd0, log_dat[0]}, 32'h0000_00A5);
        chk("t5_idx", {29'd0, log_idx[0]}, 0);
        run(18);

        // start and stop together; full-depth wrap
        clr_log();
        i_start = 1; i_stop = 1; i_len = 3; i_dwell = 2; i_loop = 0;
        step();
        i_start = 0; i_stop = 0;
        run(3);
        chk("t6_ss_n", log_dat.size(), 0);
        chk("t6_ss_busy", {31'd0, o_busy}, 0);
        for (int i = 0; i < 8; i++) wr(3'(i), 8'((i + 1) * 17));
        clr_log();
        start(8, 1, 1);
        run(20);
        chk("t6_wrap_n", log_dat.size(), 11);
        for (int i = 0; i < 11; i++) begin
            chk("t6_wrap_idx", {29'd0, log_idx[i]}, i % 8);
            chk("t6_wrap_dat", {24'd0, log_dat[i]}, ((i % 8) + 1) * 17);
        end
        stop_pulse();
        run(3);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_wr_en   = ($urandom_range(3) == 0);
            i_wr_addr = 3'($urandom_range(7));
            i_wr_data = 8'($urandom);
            i_start   = ($urandom_range(7) == 0);
            i_stop    = ($urandom_range(39) == 0);
            i_len     = 4'($urandom_range(8));
            i_dwell   = 24'($urandom_range(4));
            i_loop    = 1'($urandom_range(1));
            step();
        end
        i_wr_en = 0; i_start = 0; i_stop = 0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
